// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with a ready/valid holding register.
// Optional even-parity bit between bit 7 and the stop bit when the macro
// UART_RX_PARITY_EN is defined; otherwise parity_error is tied low.

module uart_receiver #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       parity_error
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CW               = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CW-1:0] EDGE_LAST   = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);

    // state     | meaning
    // IDLE      | line idle, waiting for a falling edge (only when armed)
    // START     | half a bit into the start bit, confirm it is still low
    // DATA      | sample 8 data bits, LSB first, one per bit period
    // PARITY    | sample the even-parity bit (parity builds only)
    // STOP      | sample the stop bit, deliver or flag framing error
    // WAIT_IDLE | after a framing error, wait for the line to return high
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_sync1;
    logic            r_sync2;
    logic [1:0]      r_fill;
    logic            r_armed;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_frame_err;
    logic            r_overrun;

    logic            w_rx_s;
    logic            w_edge;
    logic            w_mid;
    logic            w_cnt_clr;
    logic            w_shift;
    logic            w_stop_ok;
    logic            w_stop_bad;
    logic            w_consume;
`ifdef UART_RX_PARITY_EN
    logic            w_par_chk;
    logic            r_par_err;
`endif

    assign w_rx_s    = r_sync2;
    assign w_edge    = (r_cnt == EDGE_LAST);
    assign w_mid     = (r_cnt == SAMPLE_LAST);
    assign w_consume = r_valid & data_out_ready;

    // Two-flop synchronizer on the asynchronous line, idle-high reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= serial_in;
            r_sync2 <= r_sync1;
        end
    end

    // Arm only on a genuine high line: the synchronizer's reset 1s must flush
    // out first, or a line held low through reset would look like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_fill <= {r_fill[0], 1'b1};
            if (r_fill[1] && w_rx_s)
                r_armed <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic and per-cycle sample strobes.
    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_shift      = 1'b0;
        w_stop_ok    = 1'b0;
        w_stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_chk    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (r_armed && !w_rx_s) begin
                    w_state_next = S_START;
                    w_cnt_clr    = 1'b1;
                end
            end
            S_START: begin
                if (w_mid) begin
                    if (w_rx_s) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_DATA;
                        w_cnt_clr    = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_edge) begin
                    w_shift   = 1'b1;
                    w_cnt_clr = 1'b1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_edge) begin
                    w_par_chk    = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_edge) begin
                    w_cnt_clr = 1'b1;
                    if (w_rx_s) begin
                        w_stop_ok    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_stop_bad   = 1'b1;
                        w_state_next = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (w_rx_s)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bit-period counter: held at zero while idle, restarted at each sample.
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (r_state == S_IDLE || r_state == S_WAIT_IDLE || w_cnt_clr)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

    // Data shift register, LSB first, and the index of the next data bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= 8'h00;
            r_bit_idx <= 3'd0;
        end else begin
            if (r_state == S_IDLE)
                r_bit_idx <= 3'd0;
            else if (w_shift)
                r_bit_idx <= r_bit_idx + 3'd1;
            if (w_shift)
                r_shift <= {w_rx_s, r_shift[7:1]};
        end
    end

    // Holding register: a good stop bit loads it unless a full, unconsumed
    // byte is still waiting, in which case the new byte is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= 1'b0;
            r_frame_err <= w_stop_bad;
            if (w_stop_ok && (!r_valid || w_consume)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else begin
                if (w_stop_ok)
                    r_overrun <= 1'b1;
                if (w_consume)
                    r_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the parity bit must equal the XOR of the 8 data bits.
    always_ff @(posedge clk) begin
        if (rst)
            r_par_err <= 1'b0;
        else
            r_par_err <= w_par_chk && (w_rx_s != ^r_shift);
    end

    assign parity_error = r_par_err;
`else
    assign parity_error = 1'b0;
`endif

    assign data_out       = r_data;
    assign data_out_valid = r_valid;
    assign framing_error  = r_frame_err;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver with E=10, S=5 clocks per bit.
// Build with UART_RX_PARITY_EN defined to exercise the 8E1 frame.

module tb_uart_receiver;

    localparam int CF = 1_000_000;
    localparam int BR = 100_000;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 108;
`else
    localparam int LAT = 98;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_in = 1'b1;
    logic       data_out_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       framing_error;
    logic       overrun;
    logic       parity_error;

    uart_receiver #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .framing_error  (framing_error),
        .overrun        (overrun),
        .parity_error   (parity_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   fe_tot = 0, ov_tot = 0, pe_tot = 0, rise_tot = 0, last_rise = 0;
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (framing_error) fe_tot++;
        if (overrun)       ov_tot++;
        if (parity_error)  pe_tot++;
        if (data_out_valid && !prev_v) begin
            rise_tot++;
            last_rise = cyc;
        end
        prev_v = data_out_valid;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int start_cyc = 0;
    int b_rise, b_fe, b_ov, b_pe;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop_b);
    endtask

    task automatic drain();
        data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        data_out_ready = 1'b0;
    endtask

    task automatic snap();
        b_rise = rise_tot;
        b_fe   = fe_tot;
        b_ov   = ov_tot;
        b_pe   = pe_tot;
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check("rst_data", data_out, 8'h00);
        check("rst_valid", data_out_valid, 1'b0);
        check("rst_fe", framing_error, 1'b0);
        check("rst_ov", overrun, 1'b0);
        check("rst_pe", parity_error, 1'b0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // single byte, held until consumed
        snap();
        send_frame(8'hA5, 1'b1);
        check("a5_latency", last_rise - start_cyc, LAT);
        check("a5_data", data_out, 8'hA5);
        check("a5_valid", data_out_valid, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("a5_hold_valid", data_out_valid, 1'b1);
        check("a5_hold_data", data_out, 8'hA5);
        drain();
        check("a5_consumed", data_out_valid, 1'b0);
        check("a5_no_fe", fe_tot - b_fe, 0);
        check("a5_no_ov", ov_tot - b_ov, 0);

        // back-to-back frames without consuming: overrun on the second
        snap();
        send_frame(8'h3C, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("ovr_data", data_out, 8'h3C);
        check("ovr_valid", data_out_valid, 1'b1);
        check("ovr_pulses", ov_tot - b_ov, 1);
        check("ovr_no_fe", fe_tot - b_fe, 0);
        check("ovr_one_rise", rise_tot - b_rise, 1);

        // consume on exactly the load edge: new byte taken, no overrun
        snap();
        fork
            send_frame(8'h96, 1'b1);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1;
                data_out_ready = 1'b1;
                @(posedge clk);
                #1;
                data_out_ready = 1'b0;
            end
        join
        check("swap_data", data_out, 8'h96);
        check("swap_valid", data_out_valid, 1'b1);
        check("swap_no_ov", ov_tot - b_ov, 0);
        drain();

        // short low glitch is rejected at the start-bit midpoint
        snap();
        serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        serial_in = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("glitch_no_rise", rise_tot - b_rise, 0);
        check("glitch_no_fe", fe_tot - b_fe, 0);
        check("glitch_valid", data_out_valid, 1'b0);
        send_frame(8'h01, 1'b1);
        check("g01_data", data_out, 8'h01);
        check("g01_latency", last_rise - start_cyc, LAT);
        drain();

        // stop bit low, line held low: one framing error, nothing delivered
        snap();
        send_frame(8'h55, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        check("fe_pulses", fe_tot - b_fe, 1);
        check("fe_no_rise", rise_tot - b_rise, 0);
        check("fe_valid", data_out_valid, 1'b0);
        serial_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send_frame(8'h80, 1'b1);
        check("f80_data", data_out, 8'h80);
        check("f80_valid", data_out_valid, 1'b1);
        check("f80_latency", last_rise - start_cyc, LAT);
        check("f80_fe_total", fe_tot - b_fe, 1);
        drain();

        // line low across reset release must not start a frame
        rst = 1'b1;
        serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        snap();
        repeat (30) @(posedge clk);
        #1;
        serial_in = 1'b1;
        repeat (120) @(posedge clk);
        #1;
        check("lowrst_no_rise", rise_tot - b_rise, 0);
        check("lowrst_no_fe", fe_tot - b_fe, 0);
        send_frame(8'h42, 1'b1);
        check("r42_data", data_out, 8'h42);
        check("r42_latency", last_rise - start_cyc, LAT);

        // reset mid-frame with a byte still held
        serial_in = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_data", data_out, 8'h00);
        check("midrst_valid", data_out_valid, 1'b0);
        check("midrst_fe", framing_error, 1'b0);
        check("midrst_ov", overrun, 1'b0);
        check("midrst_pe", parity_error, 1'b0);
        rst = 1'b0;
        serial_in = 1'b1;
        snap();
        repeat (100) @(posedge clk);
        #1;
        check("midrst_no_rise", rise_tot - b_rise, 0);
        send_frame(8'hC3, 1'b1);
        check("c3_data", data_out, 8'hC3);
        check("c3_latency", last_rise - start_cyc, LAT);
        check("c3_no_fe", fe_tot - b_fe, 0);
        drain();

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h07, 1'b1);
        check("p07_latency", last_rise - start_cyc, 108);
        check("p07_data", data_out, 8'h07);
        check("p07_no_pe", pe_tot - b_pe, 0);
        drain();
        snap();
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        check("pbad_data", data_out, 8'h07);
        check("pbad_valid", data_out_valid, 1'b1);
        check("pbad_pe", pe_tot - b_pe, 1);
        drain();
`else
        check("pe_tied_low", pe_tot, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver for the CPU's `FPGA_SERIAL_RX` path, the receive-side counterpart of the on-chip UART transmitter. It recovers 8N1 frames (or 8E1 with parity compiled in) from the asynchronous serial line. Each byte is presented to the CPU's memory-mapped UART through a ready/valid holding register. The block runs on `cpu_clk` after the top-level IOB input register.

## Interface
- `CLOCK_FREQ`, 125_000_000, clock frequency in Hz
- `BAUD_RATE`, 115_200, line rate in bit/s
- `clk`  input  1  system clock; all logic is on the rising edge
- `rst`  input  1  synchronous, active-high reset
- `serial_in`  input  1  asynchronous serial line; idle high
- `data_out`  output  8  received byte
- `data_out_valid`  output  1  holding register is full
- `data_out_ready`  input  1  consumer accepts the byte
- `framing_error`  output  1  one-cycle pulse: stop bit sampled low
- `overrun`  output  1  one-cycle pulse: frame completed while the holding register was full
- `parity_error`  output  1  one-cycle pulse; driven 0 unless `UART_RX_PARITY_EN` is defined

## Operation
- Derived constants:
  - `SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE` (integer division).
  - `SAMPLE_TIME = SYMBOL_EDGE_TIME / 2`.
  - The counter width is `$clog2(SYMBOL_EDGE_TIME)`.
- Input synchronizer:
  - Two flops on `serial_in`, both reset to 1; the output is `rx_s`.
  - Frame logic uses only `rx_s`.
- Arming:
  - After reset the receiver is disarmed.
  - It arms once `rx_s` == 1 has been seen for one cycle, so a line held low at reset release is never taken as a start bit.
- FSM states are IDLE, START, DATA, PARITY (parity builds only), STOP and WAIT_IDLE.
  - IDLE: when armed and `rx_s` == 0, clear the counter and go to START.
  - START: at counter == SAMPLE_TIME-1, sample `rx_s`. If it is 1, treat it as a glitch and return to IDLE. If it is 0, clear the counter and go to DATA.
  - DATA: at counter == SYMBOL_EDGE_TIME-1, sample and shift the bit LSB-first into the shift register. After bit 7 go to PARITY or STOP.
  - PARITY: sample at SYMBOL_EDGE_TIME-1 and compare against the even parity of the 8 data bits.
  - STOP: sample at SYMBOL_EDGE_TIME-1.
    - If the stop bit is 1, deliver the byte and go to IDLE.
    - If it is 0, pulse `framing_error`, deliver nothing and go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s` == 1, then go to IDLE.
- Delivery:
  - If the holding register is empty, or is being consumed in the same cycle, load `data_out` and set `data_out_valid`.
  - Otherwise pulse `overrun`, keep the old byte and drop the new one.
- Handshake: `data_out_valid` clears on the edge where `valid && ready`. `data_out` is stable while valid is high.
- Reset mid-frame:
  - FSM goes to IDLE, the receiver disarms, counter is 0.
  - `data_out` goes to 0 and `data_out_valid` to 0.
  - Any byte in flight is discarded.

## Timing
- Reset values: `data_out` = 0; `data_out_valid`, `framing_error`, `overrun` and `parity_error` = 0.
- Synchronizer latency is 2 cycles from `serial_in` to `rx_s`.
- Sample points, with T0 the cycle IDLE sees `rx_s` == 0 and S = SAMPLE_TIME, E = SYMBOL_EDGE_TIME:
  - start bit at T0+S
  - data bit i at T0+S+(i+1)·E
  - parity bit at T0+S+9·E
  - stop bit at T0+S+(9+P)·E, where P = 1 with parity, else 0
- `data_out_valid` rises the cycle after the stop sample.
- `framing_error`, `overrun` and `parity_error` are each high for exactly one cycle, the cycle after the relevant sample.
- A byte with a parity error is still delivered.
- A new start bit is detected in the first IDLE cycle; frames may arrive back-to-back.
- Consume and new-byte load in the same cycle: the new byte is loaded, valid stays 1, and there is no overrun.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state is present and one even-parity bit is expected between bit 7 and the stop bit.
  - `parity_error` pulses on mismatch.
- Not defined:
  - The frame is 8N1.
  - `parity_error` is tied to 0 and the PARITY state does not exist.

## Test plan
Use CLOCK_FREQ=1_000_000 and BAUD_RATE=100_000, giving E=10 and S=5.

- Send 0xA5 as 8N1 with `data_out_ready`=0 → `data_out_valid` rises at T0+96 with `data_out`=0xA5 and holds. Raise ready for one cycle → valid is 0 on the next cycle.
- Send 0x3C followed immediately by 0xFF, never asserting ready → first byte 0x3C is retained, `overrun` pulses once at the second stop, no other error pulses.
- Send a low glitch of 3 cycles while idle → no state change, no valid, no error pulses. Then send 0x01 → 0x01 is received correctly.
- Send a frame 0x55 with the stop bit driven 0 and the line held low 50 cycles → `framing_error` pulses once, no valid, nothing received until the line goes high. Then send 0x80 → 0x80 is received.
- Hold `serial_in` low across reset release for 30 cycles → no frame starts. Then send 0x42 → 0x42 is received. In a separate run, assert `rst` mid-frame → all outputs are 0 and the next frame is received cleanly.
- With `UART_RX_PARITY_EN`, send 0x07 with parity bit 1 → valid rises at T0+106, `parity_error`=0. Send 0x07 with parity bit 0 → byte is delivered and `parity_error` pulses once.
